// File: rtl/driver_interface_pkg.sv
// Shared constants for the streaming-sample bus slave: register map,
// STATUS word layout and the STATUS word builder.
package driver_interface_pkg;

  localparam int   DATA_SIZE_DFLT    = 28;
  localparam int   COUNT_WIDTH       = 16;
  localparam logic ADDR_DATA         = 1'b0;
  localparam logic ADDR_STATUS       = 1'b1;
  localparam int   STAT_NEW_DATA_BIT = 0;
  localparam int   STAT_OVERFLOW_BIT = 1;
  localparam int   STAT_COUNT_LSB    = 16;

  // Packs the flags and sample count into the 32-bit STATUS word.
  function automatic logic [31:0] status_word(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic                   ovf,
    input logic                   nd
  );
    logic [31:0] word;
    word                                   = 32'h0000_0000;
    word[STAT_COUNT_LSB +: COUNT_WIDTH]    = cnt;
    word[STAT_OVERFLOW_BIT]                = ovf;
    word[STAT_NEW_DATA_BIT]                = nd;
    return word;
  endfunction

endpackage

// File: rtl/driver_interface.sv
// Bus slave capturing a streamed sample; exposes the latest sample (DATA) and
// new-data/overflow flags plus a transfer count (STATUS) with 1-cycle reads.
module driver_interface
  import driver_interface_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic                 address,
  input  logic                 read,
  input  logic                 source_valid,
  input  logic [DATA_SIZE-1:0] source_data,
  output logic                 source_ready,
  output logic [31:0]          read_data,
  output logic                 irq
);

  logic [DATA_SIZE-1:0]   sample_q, sample_d;
  logic                   new_data_q, new_data_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]            read_data_q, read_data_d;

  logic        transfer_s;
  logic        access_s;
  logic        data_rd_s;
  logic        stat_rd_s;
  logic        ovf_set_s;
  logic [31:0] data_ext_s;
  logic [31:0] rd_mux_s;

  assign source_ready = 1'b1;
  assign irq          = 1'b0;
  assign read_data    = read_data_q;

  assign transfer_s = source_valid;
  assign access_s   = chipselect & read;
  assign data_rd_s  = access_s & (address == ADDR_DATA);
  assign stat_rd_s  = access_s & (address == ADDR_STATUS);
  // A DATA read on the same edge consumes the old sample, so no overflow.
  assign ovf_set_s  = transfer_s & new_data_q & ~data_rd_s;

  // Read mux: zero-extended sample or status word.
  always_comb begin
    data_ext_s                  = 32'h0000_0000;
    data_ext_s[DATA_SIZE-1:0]   = sample_q;
    rd_mux_s                    = 32'h0000_0000;
    case (address)
      ADDR_DATA:   rd_mux_s = data_ext_s;
      ADDR_STATUS: rd_mux_s = status_word(count_q, overflow_q, new_data_q);
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic for sample, flags, counter and read data.
  always_comb begin
    sample_d    = sample_q;
    new_data_d  = new_data_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    read_data_d = read_data_q;

    if (transfer_s) begin
      sample_d   = source_data;
      count_d    = count_q + 16'd1;
      new_data_d = 1'b1;
    end else if (data_rd_s) begin
      new_data_d = 1'b0;
    end else begin
      new_data_d = new_data_q;
    end

    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (stat_rd_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (access_s) begin
      read_data_d = rd_mux_s;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q    <= '0;
      new_data_q  <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= 16'd0;
      read_data_q <= 32'h0000_0000;
    end else begin
      sample_q    <= sample_d;
      new_data_q  <= new_data_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
    end
  end

endmodule

// File: tb/tb_driver_interface.sv
// Self-checking bench: directed vector table with hand-computed expectations,
// then randomized traffic checked against a behavioural model of the slave.
module tb_driver_interface;

  localparam int DW = 28;

  logic          clk;
  logic          rst;
  logic          chipselect;
  logic          address;
  logic          read;
  logic          source_valid;
  logic [DW-1:0] source_data;
  logic          source_ready;
  logic [31:0]   read_data;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b0;

  // Behavioural model state
  logic [31:0] m_sample;
  bit          m_nd;
  bit          m_ovf;
  int          m_count;
  logic [31:0] m_rd;

  typedef struct {
    bit          r;
    bit          c;
    bit          a;
    bit          rd;
    bit          v;
    logic [27:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  driver_interface #(.DATA_SIZE(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .chipselect   (chipselect),
    .address      (address),
    .read         (read),
    .source_valid (source_valid),
    .source_data  (source_data),
    .source_ready (source_ready),
    .read_data    (read_data),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Constant outputs checked on every falling edge, in and out of reset.
  always @(negedge clk) begin
    if (running) begin
      check("source_ready", {31'd0, source_ready}, 32'd1);
      check("irq", {31'd0, irq}, 32'd0);
    end
  end

  // Applies one edge worth of spec rules to the model, using pre-edge state.
  task automatic model_edge(input bit r, input bit c, input bit a, input bit rd,
                            input bit v, input logic [DW-1:0] d);
    bit acc, drd, srd, set_ovf;
    if (r) begin
      m_sample = 32'd0; m_nd = 1'b0; m_ovf = 1'b0; m_count = 0; m_rd = 32'd0;
      return;
    end
    acc = c && rd;
    drd = acc && !a;
    srd = acc && a;
    if (acc)
      m_rd = a ? (m_count * 65536 + (m_ovf ? 2 : 0) + (m_nd ? 1 : 0)) : m_sample;
    set_ovf = v && m_nd && !drd;
    if (v) begin
      m_sample = {4'd0, d};
      m_count  = (m_count + 1) % 65536;
      m_nd     = 1'b1;
    end else if (drd) begin
      m_nd = 1'b0;
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (srd) m_ovf = 1'b0;
  endtask

  task automatic step(input bit r, input bit c, input bit a, input bit rd,
                      input bit v, input logic [DW-1:0] d);
    rst = r; chipselect = c; address = a; read = rd; source_valid = v; source_data = d;
    @(posedge clk);
    model_edge(r, c, a, rd, v, d);
    #1;
    check("model_read_data", read_data, m_rd);
  endtask

  task automatic add(input bit r, input bit c, input bit a, input bit rd,
                     input bit v, input logic [27:0] d, input logic [31:0] exp);
    vec_t t;
    t.r = r; t.c = c; t.a = a; t.rd = rd; t.v = v; t.d = d; t.exp = exp;
    vq.push_back(t);
  endtask

  initial begin
    rst = 1'b1; chipselect = 1'b0; address = 1'b0; read = 1'b0;
    source_valid = 1'b0; source_data = '0;
    m_sample = 32'd0; m_nd = 1'b0; m_ovf = 1'b0; m_count = 0; m_rd = 32'd0;

    //  r  c  a  rd v  data          expected read_data after the edge
    add(1, 0, 0, 0, 0, 28'h0000000, 32'h00000000);
    add(1, 1, 0, 1, 1, 28'hFFFFFFF, 32'h00000000);
    add(0, 0, 0, 0, 0, 28'h0000000, 32'h00000000);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00000000);
    add(0, 0, 0, 0, 1, 28'h1234567, 32'h00000000);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h01234567);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00010000);
    add(0, 0, 0, 0, 0, 28'h0000000, 32'h00010000);
    add(0, 0, 0, 0, 1, 28'hABCDEF0, 32'h00010000);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h0ABCDEF0);
    add(0, 0, 0, 0, 1, 28'h9876543, 32'h0ABCDEF0);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h09876543);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00030000);
    add(1, 0, 0, 0, 0, 28'h0000000, 32'h00000000);
    add(0, 0, 0, 0, 1, 28'h1111111, 32'h00000000);
    add(0, 0, 0, 0, 1, 28'h2222222, 32'h00000000);
    add(0, 0, 0, 0, 1, 28'h3333333, 32'h00000000);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00030003);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h03333333);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00030000);
    add(0, 0, 0, 0, 1, 28'h0555555, 32'h00030000);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h00555555);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h00555555);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h00555555);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00040000);
    add(0, 0, 0, 1, 1, 28'h0000AAA, 32'h00040000);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00050001);
    add(0, 1, 0, 1, 1, 28'h0BBBBBB, 32'h00000AAA);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00060001);
    add(0, 1, 1, 1, 1, 28'h0CCCCCC, 32'h00060001);
    add(0, 1, 1, 1, 1, 28'h0DDDDDD, 32'h00070003);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00080003);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h00DDDDDD);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00080000);
    add(1, 0, 0, 0, 1, 28'h0EEEEEE, 32'h00000000);
    add(0, 1, 1, 1, 0, 28'h0000000, 32'h00000000);
    add(0, 1, 0, 1, 0, 28'h0000000, 32'h00000000);

    running = 1'b1;
    foreach (vq[i]) begin
      step(vq[i].r, vq[i].c, vq[i].a, vq[i].rd, vq[i].v, vq[i].d);
      check($sformatf("vec%0d", i), read_data, vq[i].exp);
    end

    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, DW'($urandom));
    end

    step(0, 0, 0, 0, 0, '0);
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/driver_interface.md
DRIVER_INTERFACE -- requirements
Module: driver_interface

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 28, giving the width of a streamed sample (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port chipselect, input, 1 bit: selects this slave for a bus access.
REQ-005 The block SHALL have port address, input, 1 bit: register select, 0 = DATA, 1 = STATUS.
REQ-006 The block SHALL have port read, input, 1 bit: read strobe, qualified by chipselect.
REQ-007 The block SHALL have port source_valid, input, 1 bit: the stream sample on source_data is valid.
REQ-008 The block SHALL have port source_data, input, DATA_SIZE bits: the stream sample.
REQ-009 The block SHALL have port source_ready, output, 1 bit: stream backpressure, tied to 1.
REQ-010 The block SHALL have port read_data, output, 32 bits: bus read data.
REQ-011 The block SHALL have port irq, output, 1 bit: interrupt, tied to 0.

Function
REQ-012 source_ready SHALL be constant 1, in and out of reset; every cycle with source_valid=1 is a transfer.
REQ-013 On a transfer, the sample register SHALL load source_data on that edge; back-to-back transfers overwrite, so the last one wins.
REQ-014 On a transfer, new_data SHALL be set; if new_data was already 1 and no DATA read clears it on the same edge, overflow SHALL be set.
REQ-015 On a transfer, the 16-bit sample_count SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-016 A read access (chipselect=1 and read=1) SHALL register read_data on the edge, giving 1-cycle latency.
REQ-017 read_data SHALL hold its value in every cycle without a read access.
REQ-018 A DATA read SHALL return the sample register zero-extended to 32 bits.
REQ-019 A STATUS read SHALL return {sample_count[15:0], 14'b0, overflow, new_data}.
REQ-020 A DATA read SHALL clear new_data.
REQ-021 A STATUS read SHALL clear overflow.
REQ-022 If a transfer and a DATA read occur on the same edge, read_data SHALL get the old sample and new_data SHALL remain 1; overflow SHALL not be set by that transfer.
REQ-023 If a transfer and a STATUS read occur on the same edge, read_data SHALL show the pre-edge status.
REQ-024 If an overflow set and an overflow clear coincide, the set SHALL win.
REQ-025 A read held asserted over consecutive cycles SHALL be treated as a new access every cycle.
REQ-026 read=1 with chipselect=0 SHALL have no effect.
REQ-027 irq SHALL be constant 0.

Reset
REQ-028 While rst=1 at an edge, the following SHALL be cleared to 0: sample, new_data, overflow, sample_count and read_data.
REQ-029 While rst=1, transfers and reads SHALL be ignored, and source_ready SHALL stay 1.
REQ-030 A reset asserted mid-stream SHALL discard the pending sample, with no partial state kept.

Structure
REQ-031 A shared package SHALL hold these constants: DATA_SIZE default, ADDR_DATA=0, ADDR_STATUS=1, STATUS bit positions, and COUNT_WIDTH=16.
REQ-032 The block SHALL be a single module with no sub-modules, with one sequential process and combinational read mux.

Verification
REQ-033 Reset scenario: hold rst 2 cycles, then release -> read_data=0; a STATUS read returns 0x00000000; source_ready=1 and irq=0 throughout.
REQ-034 Single-transfer scenario: one transfer of 0x1234567, then a DATA read -> read_data=0x01234567 one cycle later; a following STATUS read returns 0x00010000.
REQ-035 Sequential scenario: transfer 0xABCDEF0, DATA read, transfer 0x9876543, DATA read -> reads return 0x0ABCDEF0 then 0x09876543, with no overflow.
REQ-036 Back-to-back scenario: transfers 0x1111111, 0x2222222, 0x3333333 on consecutive cycles, then a STATUS read -> 0x00030003 (count 3, overflow, new_data); a DATA read then returns 0x03333333; a second STATUS read returns 0x00030000.
REQ-037 Held-read scenario: keep chipselect=read=1 on DATA for 3 cycles -> read_data stable at the last sample; new_data cleared after the first edge.
REQ-038 Assertions SHALL run on every clock edge for the whole simulation: source_ready==1 and irq==0.
